// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with dead-time and a double-buffered display word.
// Optional leading-zero blanking: define LZ_BLANK_EN.
module seven_seg_scan_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter int DEAD_CYCLES = 1000,
  parameter int N_DIGITS    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        enable,
  output logic [3:0]  nibble,
  output logic [2:0]  digit_sel,
  output logic [7:0]  anodos,
  output logic        frame_done
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] ON_LAST   = CW'(TICK_DIV - DEAD_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(TICK_DIV - 1);
  localparam logic [2:0]    DIG_LAST  = 3'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    DEAD
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    dig_q, dig_n;
  logic [7:0]    an_q, an_n;
  logic          fd_q, fd_n;
  logic [31:0]   active_q, active_n;
  logic [31:0]   pending_q;
  logic          pend_q;
  logic          load;
  logic          wrap;
  logic          xfer;
  logic          lit;

  assign load = load_valid && !pend_q;

  assign wrap = enable && (state_q != IDLE) &&
                (cnt_q == SLOT_LAST) && (dig_q == DIG_LAST);

  assign xfer = pend_q && ((state_q == IDLE) || wrap);

  assign active_n = xfer ? pending_q : active_q;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    dig_n   = dig_q;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      dig_n   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_n = ON;
          cnt_n   = '0;
          dig_n   = '0;
        end
        ON, DEAD: begin
          // slot end covers both ON->next (no dead time) and DEAD->next
          if (cnt_q == SLOT_LAST) begin
            state_n = ON;
            cnt_n   = '0;
            dig_n   = (dig_q == DIG_LAST) ? 3'd0 : dig_q + 3'd1;
          end else begin
            cnt_n = cnt_q + 1'b1;
            if (state_q == ON && cnt_q == ON_LAST)
              state_n = DEAD;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          dig_n   = '0;
        end
      endcase
    end
  end

`ifdef LZ_BLANK_EN
  logic [2:0] msd;

  always_comb begin
    msd = 3'd0;
    for (int k = 0; k < N_DIGITS; k++)
      if (active_n[4*k +: 4] != 4'h0)
        msd = 3'(k);
    lit = (dig_n <= msd);
  end
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    an_n = 8'hFF;
    if (state_n == ON && lit)
      an_n = ~(8'h01 << dig_n);
    fd_n = (state_n != IDLE) && (cnt_n == SLOT_LAST) &&
           (dig_n == DIG_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dig_q     <= '0;
      an_q      <= 8'hFF;
      fd_q      <= 1'b0;
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      dig_q    <= dig_n;
      an_q     <= an_n;
      fd_q     <= fd_n;
      active_q <= active_n;
      if (load) begin
        pending_q <= value_in;
        pend_q    <= 1'b1;
      end else if (xfer) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign load_ready = !pend_q;
  assign nibble     = active_q[{dig_q, 2'b00} +: 4];
  assign digit_sel  = dig_q;
  assign anodos     = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (TICK_DIV=10, DEAD_CYCLES=2, N_DIGITS=4).
// A second instance with DEAD_CYCLES=0 covers back-to-back slots.
module tb_seven_seg_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] value_in;
  logic        load_valid;
  logic        load_ready;
  logic        enable;
  logic [3:0]  nibble;
  logic [2:0]  digit_sel;
  logic [7:0]  anodos;
  logic        frame_done;

  logic        enable2;
  logic        load_ready2;
  logic [3:0]  nibble2;
  logic [2:0]  digit_sel2;
  logic [7:0]  anodos2;
  logic        frame_done2;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  seven_seg_scan_ctrl #(
    .TICK_DIV(10), .DEAD_CYCLES(2), .N_DIGITS(4)
  ) u_dut (
    .clock(clock), .reset(reset),
    .value_in(value_in), .load_valid(load_valid),
    .load_ready(load_ready), .enable(enable),
    .nibble(nibble), .digit_sel(digit_sel),
    .anodos(anodos), .frame_done(frame_done)
  );

  seven_seg_scan_ctrl #(
    .TICK_DIV(10), .DEAD_CYCLES(0), .N_DIGITS(4)
  ) u_nodead (
    .clock(clock), .reset(reset),
    .value_in(value_in), .load_valid(1'b0),
    .load_ready(load_ready2), .enable(enable2),
    .nibble(nibble2), .digit_sel(digit_sel2),
    .anodos(anodos2), .frame_done(frame_done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // cycle i counts from 1 at the first ON cycle after leaving IDLE
  task automatic check_cycle(input int i, input logic [31:0] v,
                             input logic [3:0] mask);
    int slot;
    int pos;
    logic [7:0] ea;
    slot = ((i - 1) / 10) % 4;
    pos  = (i - 1) % 10;
    ea   = (pos < 8 && mask[slot]) ? ~(8'h01 << slot) : 8'hFF;
    chk($sformatf("anodos@%0d", i), {24'h0, anodos}, {24'h0, ea});
    chk($sformatf("nibble@%0d", i), {28'h0, nibble},
        {28'h0, v[4*slot +: 4]});
    chk($sformatf("digit_sel@%0d", i), {29'h0, digit_sel},
        32'(slot));
    chk($sformatf("frame_done@%0d", i), {31'h0, frame_done},
        {31'h0, (i % 40 == 0)});
  endtask

  initial begin
    logic [3:0] m40;
    logic [3:0] m0;
`ifdef LZ_BLANK_EN
    m40 = 4'b0011;
    m0  = 4'b0001;
`else
    m40 = 4'b1111;
    m0  = 4'b1111;
`endif
    reset      = 1'b1;
    enable     = 1'b0;
    enable2    = 1'b0;
    load_valid = 1'b0;
    value_in   = 32'h0;
    #2;
    chk("rst_anodos", {24'h0, anodos}, 32'hFF);
    chk("rst_ready", {31'h0, load_ready}, 32'h1);
    chk("rst_nibble", {28'h0, nibble}, 32'h0);
    chk("rst_digit", {29'h0, digit_sel}, 32'h0);
    chk("rst_fd", {31'h0, frame_done}, 32'h0);
    #20;
    reset = 1'b0;

    // load in IDLE, transfer on the following IDLE cycle
    step();
    value_in   = 32'h1234;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("idle_ready_low", {31'h0, load_ready}, 32'h0);
    step();
    chk("idle_ready_back", {31'h0, load_ready}, 32'h1);
    chk("idle_anodos", {24'h0, anodos}, 32'hFF);
    enable = 1'b1;
    for (int i = 1; i <= 41; i++) begin
      step();
      check_cycle(i, 32'h1234, 4'hF);
    end

    // mid-frame load: 0xABCD waits for the wrap, 0x5555 held behind it
    value_in   = 32'hABCD;
    load_valid = 1'b1;
    for (int i = 42; i <= 80; i++) begin
      step();
      if (i == 42) value_in = 32'h5555;
      check_cycle(i, 32'h1234, 4'hF);
      chk($sformatf("ready_lo@%0d", i), {31'h0, load_ready}, 32'h0);
    end
    step();
    check_cycle(81, 32'hABCD, 4'hF);
    chk("ready_wrap", {31'h0, load_ready}, 32'h1);
    for (int i = 82; i <= 120; i++) begin
      step();
      if (i == 82) load_valid = 1'b0;
      check_cycle(i, 32'hABCD, 4'hF);
      chk($sformatf("ready_lo2@%0d", i), {31'h0, load_ready}, 32'h0);
    end
    for (int i = 121; i <= 143; i++) begin
      step();
      check_cycle(i, 32'h5555, 4'hF);
    end
    chk("ready_121", {31'h0, load_ready}, 32'h1);

    // disable during digit2 ON
    enable = 1'b0;
    step();
    chk("dis_anodos", {24'h0, anodos}, 32'hFF);
    chk("dis_digit", {29'h0, digit_sel}, 32'h0);
    chk("dis_fd", {31'h0, frame_done}, 32'h0);
    step();
    chk("dis_anodos2", {24'h0, anodos}, 32'hFF);
    enable = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      check_cycle(i, 32'h5555, 4'hF);
    end

    // async reset mid-ON with a pending word
    value_in   = 32'h9876;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("pre_rst_ready", {31'h0, load_ready}, 32'h0);
    chk("pre_rst_anodos", {24'h0, anodos}, 32'hFD);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_anodos", {24'h0, anodos}, 32'hFF);
    chk("arst_ready", {31'h0, load_ready}, 32'h1);
    chk("arst_nibble", {28'h0, nibble}, 32'h0);
    chk("arst_digit", {29'h0, digit_sel}, 32'h0);
    enable = 1'b0;
    #10;
    reset = 1'b0;

    // value 0x0040, then 0
    value_in   = 32'h0040;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    enable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      check_cycle(i, 32'h0040, m40);
    end
    enable     = 1'b0;
    value_in   = 32'h0;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    enable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      check_cycle(i, 32'h0, m0);
    end
    enable = 1'b0;
    step();

    // zero dead time: back-to-back 10-cycle slots
    enable2 = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      step();
      chk($sformatf("nd_anodos@%0d", i), {24'h0, anodos2},
          {24'h0, ~(8'h01 << (((i - 1) / 10) % 4))});
      chk($sformatf("nd_fd@%0d", i), {31'h0, frame_done2},
          {31'h0, (i % 40 == 0)});
    end
    enable2 = 1'b0;
    step();
    chk("nd_off", {24'h0, anodos2}, 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
